// File: rtl/rsa_operand_packer.sv
// rsa_operand_packer
// Absorbs DATA_WIDTH-bit read beats into a circular FIFO, packs WORDS of them
// into one OP_WIDTH-bit operand and offers it to the Montgomery core with a
// valid/ready handshake. A push while full is dropped and sets a sticky flag.
//
// Build option: define PACKER_MSW_FIRST_EN to pack most-significant word first
// (first word received lands in the top bits). Default is LSW first.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             synchronous clear of FIFO, packer and overflow flag
//   fifo_we_i/data_i    push strobe and word from the read master
//   fifo_full_o/empty_o FIFO occupancy flags
//   fifo_level_o        FIFO occupancy
//   op_data_o/valid_o   packed operand and its valid flag
//   op_ready_i          core accepts the operand
//   word_cnt_o          words packed into the current operand
//   overflow_o          sticky: a push was dropped
module rsa_operand_packer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned OP_WIDTH   = 1024,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                                      clk_i,
   input  logic                                      rst_i,
   input  logic                                      flush_i,
   input  logic                                      fifo_we_i,
   input  logic [DATA_WIDTH-1:0]                     fifo_data_i,
   output logic                                      fifo_full_o,
   output logic                                      fifo_empty_o,
   output logic [$clog2(FIFO_DEPTH):0]               fifo_level_o,
   output logic [OP_WIDTH-1:0]                       op_data_o,
   output logic                                      op_valid_o,
   input  logic                                      op_ready_i,
   output logic [$clog2(OP_WIDTH/DATA_WIDTH):0]      word_cnt_o,
   output logic                                      overflow_o
);

   localparam int unsigned PW    = $clog2(FIFO_DEPTH);
   localparam int unsigned LW    = PW + 1;
   localparam int unsigned WORDS = OP_WIDTH / DATA_WIDTH;
   localparam int unsigned CW    = $clog2(WORDS) + 1;

   typedef enum logic {
      COLLECT = 1'b0,
      VALID   = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wptr_q, wptr_d;
   logic [PW-1:0]         rptr_q, rptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic [OP_WIDTH-1:0]   op_q, op_d;
   logic                  valid_q, valid_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;

   logic                  push_c;
   logic                  drop_c;
   logic                  pop_c;
   logic [DATA_WIDTH-1:0] head_c;
   logic [OP_WIDTH-1:0]   packed_c;

   // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
   assign push_c = fifo_we_i & ~full_q;
   assign drop_c = fifo_we_i & full_q;
   assign pop_c  = (state_q == COLLECT) & ~empty_q;
   assign head_c = mem_q[rptr_q];

   // Shift the head word into the operand from the selected end.
`ifdef PACKER_MSW_FIRST_EN
   assign packed_c = {op_q[OP_WIDTH-DATA_WIDTH-1:0], head_c};
`else
   assign packed_c = {head_c, op_q[OP_WIDTH-1:DATA_WIDTH]};
`endif

   // FIFO storage; contents need no reset since the level gates every read.
   always_ff @(posedge clk_i) begin
      if (push_c) begin
         mem_q[wptr_q] <= fifo_data_i;
      end
   end

   // State and control registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= COLLECT;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         op_q    <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         op_q    <= op_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state: FIFO bookkeeping, packing and the COLLECT/VALID handshake.
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;

      if (push_c) begin
         wptr_d = wptr_q + PW'(1);
      end
      if (pop_c) begin
         rptr_d = rptr_q + PW'(1);
      end
      unique case ({push_c, pop_c})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      if (drop_c) begin
         ovf_d = 1'b1;
      end

      unique case (state_q)
         COLLECT: begin
            if (pop_c) begin
               op_d  = packed_c;
               cnt_d = cnt_q + CW'(1);
               if (cnt_d == CW'(WORDS)) begin
                  state_d = VALID;
               end
            end
         end
         VALID: begin
            // op_data is left as is; the next operand overwrites it by shifting.
            if (op_ready_i) begin
               state_d = COLLECT;
               cnt_d   = '0;
            end
         end
         default: state_d = COLLECT;
      endcase

      if (flush_i) begin
         state_d = COLLECT;
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
         op_d    = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end

      full_d  = (level_d == LW'(FIFO_DEPTH));
      empty_d = (level_d == '0);
      valid_d = (state_d == VALID);
   end

   assign fifo_full_o  = full_q;
   assign fifo_empty_o = empty_q;
   assign fifo_level_o = level_q;
   assign op_data_o    = op_q;
   assign op_valid_o   = valid_q;
   assign word_cnt_o   = cnt_q;
   assign overflow_o   = ovf_q;

endmodule

// File: doc/rsa_operand_packer.md
Name: rsa_operand_packer

Overview:
Sits directly downstream of the AXI read master. Absorbs the 32-bit read beats it pushes (wr_fifo_we / wr_fifo_data / wr_fifo_full) into an internal FIFO. Packs consecutive words into one OP_WIDTH-bit operand, then presents that operand to the Montgomery core with a valid/ready handshake. Also detects overflow, because the read master never stalls on fifo_full.

Parameters:
DATA_WIDTH, 32, width of one incoming word
OP_WIDTH, 1024, operand width; must be an integer multiple of DATA_WIDTH
FIFO_DEPTH, 16, internal FIFO entries; power of 2, at least 2

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous clear of FIFO, packer and overflow flag
fifo_we  in  1  push strobe from the read master
fifo_data  in  DATA_WIDTH  word to push
fifo_full  out  1  FIFO holds FIFO_DEPTH entries
fifo_empty  out  1  FIFO holds 0 entries
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
op_data  out  OP_WIDTH  packed operand
op_valid  out  1  op_data is complete and stable
op_ready  in  1  core accepts the operand
word_cnt  out  $clog2(OP_WIDTH/DATA_WIDTH)+1  words packed into the current operand
overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset: one clock, synchronous, active-high (rst). While rst=1 at a clk edge:
  - fifo_full=0, fifo_empty=1, fifo_level=0
  - op_data=0, op_valid=0, word_cnt=0, overflow=0
  - state=COLLECT
- flush: same effect as rst, at any time and in any state. It discards partial and completed operands. rst takes priority over flush.
- WORDS = OP_WIDTH/DATA_WIDTH.
- FIFO, circular buffer:
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Level register is 1 bit wider than the pointers.
  - fifo_full and fifo_empty are registered, or derived from the level register.
- Push: occurs when fifo_we=1 and fifo_full=0. The word is visible at the FIFO head after that edge.
  - fifo_we=1 while fifo_full=1: the word is dropped, overflow is set to 1 at that edge, and the level is unchanged.
  - overflow is sticky until rst or flush.
  - Push is refused when full even if a pop happens in the same cycle.
- Pop: occurs when state=COLLECT and fifo_empty=0. The head word is consumed at that edge, one word per cycle maximum.
  - Simultaneous push and pop (not full, not empty): level is unchanged and both pointers advance.
- Packing (default, LSW first): at each pop, op_data <= {head, op_data[OP_WIDTH-1:DATA_WIDTH]} and word_cnt increments. After WORDS pops, the first word occupies bits [DATA_WIDTH-1:0].
- State machine, two states:
  - COLLECT -> VALID on the pop that makes word_cnt reach WORDS. op_valid=1 from that same edge.
  - VALID: no pops; op_data is held stable; the FIFO keeps accepting pushes.
  - VALID -> COLLECT at the edge where op_valid=1 and op_ready=1. At that edge op_valid goes to 0 and word_cnt goes to 0. op_data keeps its value until it is overwritten by shifting.
  - op_ready while in COLLECT is ignored.
- Latency:
  - A word pushed at edge t is popped at edge t+1 if the state is COLLECT.
  - op_valid rises one edge after the push of the final word when words arrive back-to-back.
  - Sustained throughput is 1 word per cycle; there is a 1-cycle gap for the handshake between operands.
- Words beyond WORDS stay in the FIFO for the next operand; nothing is discarded at operand boundaries.

Optional Feature:
PACKER_MSW_FIRST_EN
- Defined: shift direction reverses: op_data <= {op_data[OP_WIDTH-DATA_WIDTH-1:0], head}. The first word received ends in bits [OP_WIDTH-1:OP_WIDTH-DATA_WIDTH], for memory images stored most-significant word first.
- Undefined: LSW-first packing as above.
- All timing, flags and handshakes are identical in both builds.

Test Plan:
1. OP_WIDTH=128, DATA_WIDTH=32. Push 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive edges with op_ready=0 -> op_valid=1 one edge after the 4th push; op_data=0x44444444_33333333_22222222_11111111; word_cnt=4. With PACKER_MSW_FIRST_EN: op_data=0x11111111_22222222_33333333_44444444.
2. Hold op_ready=0 in VALID. Push 20 words with FIFO_DEPTH=16 -> fifo_full=1 after the 16th push; pushes 17-20 are dropped; overflow=1; fifo_level stays 16; op_data is unchanged.
3. From test 2, assert op_ready for 1 cycle -> op_valid=0 next edge; 4 pops on the following edges; next op_valid after exactly 4 more edges; op_data = pushed words 1-4 of that burst. overflow stays 1.
4. Push 3 words, then assert flush -> next edge: fifo_empty=1, word_cnt=0, overflow=0, op_valid=0, op_data=0.
5. Push 16 words with op_ready tied 1 and OP_WIDTH=128 -> 4 operands delivered; the op_valid pulse pattern shows a 1-cycle gap between operands; the FIFO pointers wrap past depth 16 without data corruption.
6. Assert rst mid-collect with 2 of 4 words packed and fifo_level=3 -> all outputs are at reset values on the next edge. A subsequent 4-word push produces an operand containing only the new words.
